pusch_symbol_scheduler: RTL
===========================

Name: pusch_symbol_scheduler

Overview:
- Slot-level sequencer in front of the RE mapper: walks symbols Sym_Start..Sym_End, issues one request per symbol to the DMRS generator or the FFT source, and tracks the mapper's written REs and symbol-done flags.
- Publishes the current symbol index and its grid base address, checks the configuration, and flags per-symbol length errors and stalls.
- Sits between the slot controller (config + start) and the mapper/DMRS/FFT blocks.

Parameters:
- TOTAL_SC, 1200, subcarriers per symbol in the grid.
- MAX_SYM, 14, symbols per slot.
- TO_W, 16, timeout counter width.

Ports:
- CLK_RE  in  1  clock
- RST_RE  in  1  asynchronous reset, active-low
- EN_RE  in  1  global enable; low freezes all state, counters and outputs
- Cfg_Start  in  1  one-cycle start pulse; latches the config inputs
- N_sc  in  11  first allocated subcarrier
- N_rb  in  7  number of allocated RBs
- Sym_Start  in  4  first PUSCH symbol
- Sym_End  in  4  last PUSCH symbol
- Dmrs_Map  in  14  bit k=1 means symbol k carries DMRS
- Timeout_Lim  in  TO_W  max cycles per symbol; 0 disables the check
- Wr_Valid  in  1  mapper RE write strobe
- Sym_Done_In  in  1  mapper end-of-symbol pulse
- Dmrs_Req  out  1  one-cycle request to the DMRS generator
- Fft_Req  out  1  one-cycle request to the FFT source
- Sym_Idx  out  4  current symbol
- Is_Dmrs  out  1  current symbol is DMRS
- Grid_Base  out  15  Sym_Idx*TOTAL_SC
- Busy  out  1  slot in progress
- Slot_Done  out  1  one-cycle pulse on normal completion
- Err_Cfg  out  1  sticky: illegal configuration
- Err_Len  out  1  sticky: RE count mismatch
- Err_Timeout  out  1  sticky: symbol stalled

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- All outputs are registered; nothing advances while EN_RE=0.
- State IDLE:
  - Cfg_Start=1 latches N_sc, N_rb, Sym_Start, Sym_End, Dmrs_Map, Timeout_Lim.
  - Clears the sticky errors, sets Busy, goes to CHECK.
- State CHECK (1 cycle): the configuration is legal iff all hold:
  - Sym_Start<=Sym_End
  - Sym_End<=MAX_SYM-1
  - 1<=N_rb<=100
  - N_sc + N_rb*12 <= TOTAL_SC, computed at 12 bits
  - If legal: Sym_Idx<=Sym_Start, go to ISSUE.
  - If illegal: Err_Cfg<=1, go to ERR.
- State ISSUE (1 cycle):
  - Is_Dmrs<=Dmrs_Map[Sym_Idx]; Grid_Base<=Sym_Idx*TOTAL_SC.
  - Pulse Dmrs_Req if Is_Dmrs, else Fft_Req; exactly one of the two.
  - Clear re_cnt and to_cnt; go to RUN.
- Timing: the first request is high in the cycle 3 rising edges after Cfg_Start is sampled (counting EN_RE=1 cycles).
- State RUN:
  - re_cnt increments on each Wr_Valid; it saturates at 2047.
  - to_cnt increments every cycle.
  - On Sym_Done_In: if re_cnt, including a Wr_Valid in the same cycle, differs from N_rb*12, set Err_Len and continue. Then go to NEXT.
  - If Timeout_Lim!=0 and to_cnt reaches Timeout_Lim before Sym_Done_In: Err_Timeout<=1, go to ERR.
  - Sym_Done_In in the same cycle as the timeout hit: done wins.
- State NEXT (1 cycle):
  - If Sym_Idx==Sym_End: pulse Slot_Done, Busy<=0, go to IDLE.
  - Else: Sym_Idx<=Sym_Idx+1, go to ISSUE.
- State ERR:
  - Busy<=0; the sticky errors hold.
  - The next Cfg_Start restarts as from IDLE.
- Cfg_Start while Busy: ignored. Sym_Done_In outside RUN: ignored.
- Reset mid-slot: immediate return to IDLE with all outputs 0; no request is issued.
- Grid_Base is held constant between ISSUE instants; maximum value is 13*1200=15600, which fits 15 bits.

Test Plan:
- Sym_Start=0, Sym_End=3, Dmrs_Map=0x0001, N_rb=2, N_sc=0; 24 Wr_Valid then Sym_Done_In per symbol -> one Dmrs_Req then three Fft_Req; Grid_Base 0,1200,2400,3600; one Slot_Done; no errors.
- N_sc=1190, N_rb=1 -> Err_Cfg=1 two cycles after Cfg_Start; no request pulses; Busy drops.
- Same as the first case, but symbol 2 gets only 23 Wr_Valid -> Err_Len=1; the slot still completes with Slot_Done.
- Timeout_Lim=50, no Sym_Done_In after the first Fft_Req -> Err_Timeout=1 at to_cnt=50; state ERR; a new Cfg_Start clears the error and runs normally.
- EN_RE low for 10 cycles mid-RUN -> counters and outputs frozen; on resume the timeout count excludes the stalled cycles.
- RST_RE asserted during symbol 1 -> all outputs 0 immediately; a later Cfg_Start restarts from Sym_Start.

Source files
------------

// File: rtl/pusch_symbol_scheduler_if.sv
// pusch_symbol_scheduler_if: config, mapper-status and request/status bundle of the PUSCH symbol scheduler
// master: slot controller / mapper side, drives config and mapper status, receives requests and status
// slave:  scheduler side, receives config and mapper status, drives requests, symbol info and errors
interface pusch_symbol_scheduler_if #(
    parameter int TO_W = 16
);
    logic            Cfg_Start;
    logic [10:0]     N_sc;
    logic [6:0]      N_rb;
    logic [3:0]      Sym_Start;
    logic [3:0]      Sym_End;
    logic [13:0]     Dmrs_Map;
    logic [TO_W-1:0] Timeout_Lim;
    logic            Wr_Valid;
    logic            Sym_Done_In;
    logic            Dmrs_Req;
    logic            Fft_Req;
    logic [3:0]      Sym_Idx;
    logic            Is_Dmrs;
    logic [14:0]     Grid_Base;
    logic            Busy;
    logic            Slot_Done;
    logic            Err_Cfg;
    logic            Err_Len;
    logic            Err_Timeout;
    modport master (
        output Cfg_Start, N_sc, N_rb, Sym_Start, Sym_End, Dmrs_Map, Timeout_Lim, Wr_Valid, Sym_Done_In,
        input  Dmrs_Req, Fft_Req, Sym_Idx, Is_Dmrs, Grid_Base, Busy, Slot_Done, Err_Cfg, Err_Len, Err_Timeout
    );
    modport slave (
        input  Cfg_Start, N_sc, N_rb, Sym_Start, Sym_End, Dmrs_Map, Timeout_Lim, Wr_Valid, Sym_Done_In,
        output Dmrs_Req, Fft_Req, Sym_Idx, Is_Dmrs, Grid_Base, Busy, Slot_Done, Err_Cfg, Err_Len, Err_Timeout
    );
endinterface

// File: rtl/pusch_symbol_scheduler.sv
// pusch_symbol_scheduler: walks Sym_Start..Sym_End, issues one DMRS/FFT request per symbol and tracks mapper progress
// CLK_RE / RST_RE (async, active-low) / EN_RE (low freezes everything)
// bus (slave): config + Cfg_Start, mapper Wr_Valid / Sym_Done_In in; requests, Sym_Idx, Is_Dmrs, Grid_Base,
//              Busy, Slot_Done and sticky Err_Cfg / Err_Len / Err_Timeout out, all registered
module pusch_symbol_scheduler #(
    parameter int TOTAL_SC = 1200,
    parameter int MAX_SYM  = 14,
    parameter int TO_W     = 16
) (
    input logic                     CLK_RE,
    input logic                     RST_RE,
    input logic                     EN_RE,
    pusch_symbol_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, RUN, NEXT, ERR} state_t;
    typedef struct packed {
        state_t          st;
        logic [10:0]     n_sc;
        logic [6:0]      n_rb;
        logic [3:0]      sym_start;
        logic [3:0]      sym_end;
        logic [13:0]     dmrs_map;
        logic [TO_W-1:0] to_lim;
        logic [10:0]     re_cnt;
        logic [TO_W-1:0] to_cnt;
        logic [3:0]      sym_idx;
        logic            is_dmrs;
        logic [14:0]     grid_base;
        logic            busy;
        logic            slot_done;
        logic            dmrs_req;
        logic            fft_req;
        logic            err_cfg;
        logic            err_len;
        logic            err_to;
    } regs_t;
    regs_t r, n;
    logic [11:0]     alloc_end;
    logic            cfg_ok;
    logic [10:0]     re_tot;
    logic [10:0]     re_exp;
    logic [TO_W-1:0] to_next;
    assign alloc_end = {1'b0, r.n_sc} + {5'b0, r.n_rb} * 12'd12;
    assign cfg_ok    = (r.sym_start <= r.sym_end) && (r.sym_end <= 4'(MAX_SYM - 1)) &&
                       (r.n_rb != 7'd0) && (r.n_rb <= 7'd100) && (alloc_end <= 12'(TOTAL_SC));
    // count includes a write arriving in the same cycle as Sym_Done_In; saturates at 2047
    assign re_tot    = (r.re_cnt == 11'h7ff) ? r.re_cnt : r.re_cnt + {10'b0, bus.Wr_Valid};
    assign re_exp    = {4'b0, r.n_rb} * 11'd12;
    assign to_next   = r.to_cnt + 1'b1;
    always_comb begin
        n           = r;
        n.slot_done = 1'b0;
        n.dmrs_req  = 1'b0;
        n.fft_req   = 1'b0;
        case (r.st)
            IDLE, ERR: if (bus.Cfg_Start) begin
                n.n_sc      = bus.N_sc;
                n.n_rb      = bus.N_rb;
                n.sym_start = bus.Sym_Start;
                n.sym_end   = bus.Sym_End;
                n.dmrs_map  = bus.Dmrs_Map;
                n.to_lim    = bus.Timeout_Lim;
                n.err_cfg   = 1'b0;
                n.err_len   = 1'b0;
                n.err_to    = 1'b0;
                n.busy      = 1'b1;
                n.st        = CHECK;
            end
            CHECK: begin
                n.sym_idx = cfg_ok ? r.sym_start : r.sym_idx;
                n.err_cfg = !cfg_ok;
                n.busy    = cfg_ok;
                n.st      = cfg_ok ? ISSUE : ERR;
            end
            ISSUE: begin
                n.is_dmrs   = r.dmrs_map[r.sym_idx];
                n.grid_base = 15'(r.sym_idx) * 15'(TOTAL_SC);
                n.dmrs_req  = r.dmrs_map[r.sym_idx];
                n.fft_req   = !r.dmrs_map[r.sym_idx];
                n.re_cnt    = '0;
                n.to_cnt    = '0;
                n.st        = RUN;
            end
            RUN: begin
                n.re_cnt = re_tot;
                n.to_cnt = to_next;
                // a done in the same cycle as the timeout hit takes precedence
                if (bus.Sym_Done_In) begin
                    n.err_len = r.err_len | (re_tot != re_exp);
                    n.st      = NEXT;
                end else if (r.to_lim != '0 && to_next == r.to_lim) begin
                    n.err_to = 1'b1;
                    n.busy   = 1'b0;
                    n.st     = ERR;
                end
            end
            NEXT: begin
                n.slot_done = (r.sym_idx == r.sym_end);
                n.busy      = (r.sym_idx != r.sym_end);
                n.sym_idx   = (r.sym_idx == r.sym_end) ? r.sym_idx : r.sym_idx + 4'd1;
                n.st        = (r.sym_idx == r.sym_end) ? IDLE : ISSUE;
            end
            default: n.st = IDLE;
        endcase
    end
    always_ff @(posedge CLK_RE or negedge RST_RE) begin
        if (!RST_RE)
            r <= '0;
        else if (EN_RE)
            r <= n;
    end
    assign bus.Dmrs_Req    = r.dmrs_req;
    assign bus.Fft_Req     = r.fft_req;
    assign bus.Sym_Idx     = r.sym_idx;
    assign bus.Is_Dmrs     = r.is_dmrs;
    assign bus.Grid_Base   = r.grid_base;
    assign bus.Busy        = r.busy;
    assign bus.Slot_Done   = r.slot_done;
    assign bus.Err_Cfg     = r.err_cfg;
    assign bus.Err_Len     = r.err_len;
    assign bus.Err_Timeout = r.err_to;
endmodule
